pixel_out_serializer: RTL

//  Downstream stage of the grayscale/Sobel top. Buffers processed pixels (out_pixel_o/px_rdy_o of the

---
 rtl/pixel_out_serializer_pkg.sv | 26 ++
 rtl/pixel_out_serializer_pixel_fifo.sv | 56 +++++
 rtl/pixel_out_serializer.sv | 110 +++++++++++
 3 files changed

// File: rtl/pixel_out_serializer_pkg.sv
// Shared types and widths for the pixel output serializer.
// Holds the FIFO entry layout, FSM states and the shift-register load helper.
package pixel_out_serializer_pkg;

  localparam int MAX_PIXEL_BITS  = 24;
  localparam int PIXEL_WIDTH_OUT = 8;

  typedef struct packed {
    logic                      wide;
    logic [MAX_PIXEL_BITS-1:0] px;
  } fifo_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Narrow pixels are left-aligned so the first byte out is always sh[23:16].
  function automatic logic [MAX_PIXEL_BITS-1:0] load_shift(input fifo_entry_t e);
    if (e.wide)
      return e.px;
    else
      return {e.px[PIXEL_WIDTH_OUT-1:0], {(MAX_PIXEL_BITS-PIXEL_WIDTH_OUT){1'b0}}};
  endfunction

endpackage

// File: rtl/pixel_out_serializer_pixel_fifo.sv
// Synchronous pixel FIFO with registered count; data written this cycle is
// visible at the head no earlier than the next cycle.
module pixel_fifo
  import pixel_out_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push,
  input  fifo_entry_t                  wdata,
  input  logic                         pop,
  output fifo_entry_t                  rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fifo_entry_t     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_out_serializer.sv
// Buffers filter pixels and streams them as bytes: narrow pixels give one byte,
// wide (RGB) pixels give three bytes in R,G,B order.
module pixel_out_serializer
  import pixel_out_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [MAX_PIXEL_BITS-1:0]         px_i,
  input  logic                              px_rdy_i,
  input  logic                              wide_i,
  output logic [PIXEL_WIDTH_OUT-1:0]        byte_o,
  output logic                              byte_valid_o,
  input  logic                              byte_ready_i,
  input  logic                              clr_ovf_i,
  output logic                              overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
  output logic                              busy_o,
  output ser_state_t                        dbg_state
);

  // Byte port: a byte moves when byte_valid_o && byte_ready_i at a rising edge;
  // once raised, byte_valid_o and byte_o stay put until that transfer happens.

  ser_state_t                 state;
  ser_state_t                 state_nxt;
  logic [MAX_PIXEL_BITS-1:0]  sh;
  logic [1:0]                 bcnt;
  logic                       load;
  logic                       shift;
  logic                       hs;
  fifo_entry_t                fifo_wdata;
  fifo_entry_t                fifo_rdata;
  logic                       fifo_full;
  logic                       fifo_empty;

  assign fifo_wdata = '{wide: wide_i, px: px_i};
  assign hs         = byte_valid_o && byte_ready_i;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (px_rdy_i),
    .wdata   (fifo_wdata),
    .pop     (load),
    .rdata   (fifo_rdata),
    .count   (fifo_count_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Loading the next entry straight from SEND keeps narrow pixels gap-free.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (bcnt != 2'd0)     shift     = 1'b1;
          else if (!fifo_empty) load      = 1'b1;
          else                  state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_o       = sh[MAX_PIXEL_BITS-1 -: PIXEL_WIDTH_OUT];
    byte_valid_o = (state == SEND);
    busy_o       = (fifo_count_o != '0) || (state == SEND);
    dbg_state    = state;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sh   <= '0;
      bcnt <= '0;
    end else if (load) begin
      sh   <= load_shift(fifo_rdata);
      bcnt <= fifo_rdata.wide ? 2'd2 : 2'd0;
    end else if (shift) begin
      sh   <= sh << PIXEL_WIDTH_OUT;
      bcnt <= bcnt - 2'd1;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk_i) begin
    if (reset_i)                      overflow_o <= 1'b0;
    else if (px_rdy_i && fifo_full)   overflow_o <= 1'b1;
    else if (clr_ovf_i)               overflow_o <= 1'b0;
  end

endmodule
